// File: rtl/mm_operand_feeder_pkg.sv
// Shared types and helpers for the matrix-multiply operand feeder.
package mm_operand_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_EMIT      = 2'd2,
        ST_DONE_WAIT = 2'd3
    } feedState_e;

    // Words per job (A then B) and words per 4x4 matrix
    localparam int unsigned FEED_WORDS = 32;
    localparam int unsigned MAT_WORDS  = 16;

    // Maps an output sequence number to a buffer index:
    // A row 0, then B column by column (top to bottom), then A rows 1..3.
    function automatic logic [4:0] feedAddr(input logic [5:0] seq);
        logic [3:0] colSeq;
        logic [4:0] addr;
        colSeq = 4'(seq - 6'd4);
        if (seq < 6'd4) begin
            addr = 5'(seq);
        end else if (seq < 6'd20) begin
            // colSeq[3:2] is the column, colSeq[1:0] the row; B index is 4*row + col
            addr = 5'(MAT_WORDS) + {1'b0, colSeq[1:0], colSeq[3:2]};
        end else begin
            addr = 5'(seq - 6'(MAT_WORDS));
        end
        return addr;
    endfunction

endpackage

// File: rtl/mm_feed_buf.sv
// Job buffer: holds A (entries 0..15) and B (entries 16..31).
// One synchronous write port, one asynchronous read port; contents are never reset.
module mm_feed_buf #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 32
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(pDEPTH)-1:0]  waddr_i,
    input  logic [pDATA_WIDTH-1:0]     wdata_i,
    input  logic [$clog2(pDEPTH)-1:0]  raddr_i,
    output logic [pDATA_WIDTH-1:0]     rdata_o
);

    logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];

    // Store each accepted stream word at the current write index
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mm_operand_feeder.sv
// Operand feeder: buffers A and B from the DMA stream, then replays them in the
// order the 4x4 stream matrix-multiply engine consumes them.
module mm_operand_feeder
    import mm_operand_feeder_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int pDIM        = 4   // the engine is fixed 4x4; other values are not supported
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   feed_start,
    output logic                   feed_busy,
    output logic                   feed_done,
    output logic                   feed_err,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata
);

    localparam logic [4:0] LAST_WR = 5'(2 * pDIM * pDIM - 1);
    localparam logic [5:0] RD_END  = 6'(FEED_WORDS);

    feedState_e             state_q;
    logic [4:0]             wrCnt_q;
    logic [5:0]             rdSeq_q;
    logic                   ssTready_q;
    logic                   smTvalid_q;
    logic [pDATA_WIDTH-1:0] smTdata_q;
    logic                   feedBusy_q;
    logic                   feedDone_q;
    logic                   feedErr_q;

    logic                   ssHandshake;
    logic                   smHandshake;
    logic                   emitLoad;
    logic [4:0]             rdAddr;
    logic [pDATA_WIDTH-1:0] rdData;

    assign ssHandshake = (state_q == ST_LOAD) && ss_tvalid && ssTready_q;
    assign smHandshake = smTvalid_q && sm_tready;
    // The output register may take a new word when empty or being drained this cycle
    assign emitLoad    = (!smTvalid_q || sm_tready) && (rdSeq_q < RD_END);
    assign rdAddr      = feedAddr(rdSeq_q);

    mm_feed_buf #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pDEPTH      (FEED_WORDS)
    ) uBuf (
        .clk_i   (axis_clk),
        .we_i    (ssHandshake),
        .waddr_i (wrCnt_q),
        .wdata_i (ss_tdata),
        .raddr_i (rdAddr),
        .rdata_o (rdData)
    );

    // Job sequencer: load 32 words, replay them through the output register, pulse done
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= ST_IDLE;
            wrCnt_q    <= '0;
            rdSeq_q    <= '0;
            ssTready_q <= 1'b0;
            smTvalid_q <= 1'b0;
            smTdata_q  <= '0;
            feedBusy_q <= 1'b0;
            feedDone_q <= 1'b0;
            feedErr_q  <= 1'b0;
        end else begin
            feedDone_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (feed_start) begin
                        state_q    <= ST_LOAD;
                        wrCnt_q    <= '0;
                        feedErr_q  <= 1'b0;
                        ssTready_q <= 1'b1;
                        feedBusy_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ssHandshake) begin
                        wrCnt_q <= wrCnt_q + 5'd1;
                        // tlast only flags framing problems; it never changes the word count
                        if (ss_tlast != (wrCnt_q == LAST_WR)) begin
                            feedErr_q <= 1'b1;
                        end
                        if (wrCnt_q == LAST_WR) begin
                            state_q    <= ST_EMIT;
                            ssTready_q <= 1'b0;
                            rdSeq_q    <= '0;
                        end
                    end
                end
                ST_EMIT: begin
                    if (emitLoad) begin
                        smTdata_q  <= rdData;
                        smTvalid_q <= 1'b1;
                        rdSeq_q    <= rdSeq_q + 6'd1;
                    end else if (smHandshake) begin
                        // Only reachable once all 32 words are issued: this is the last word leaving
                        smTvalid_q <= 1'b0;
                        feedDone_q <= 1'b1;
                        state_q    <= ST_DONE_WAIT;
                    end
                end
                ST_DONE_WAIT: begin
                    state_q    <= ST_IDLE;
                    feedBusy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ss_tready = ssTready_q;
    assign sm_tvalid = smTvalid_q;
    assign sm_tdata  = smTdata_q;
    assign feed_busy = feedBusy_q;
    assign feed_done = feedDone_q;
    assign feed_err  = feedErr_q;

endmodule

// File: tb/tb_mm_operand_feeder.sv
// Randomized self-checking bench for mm_operand_feeder against a matrix-level model.
module tb_mm_operand_feeder;

    localparam int W = 32;

    logic         axis_clk = 1'b0;
    logic         axis_rst_n;
    logic         feed_start;
    logic         feed_busy;
    logic         feed_done;
    logic         feed_err;
    logic         ss_tvalid;
    logic [W-1:0] ss_tdata;
    logic         ss_tlast;
    logic         ss_tready;
    logic         sm_tready;
    logic         sm_tvalid;
    logic [W-1:0] sm_tdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastHsCyc = 0;

    logic [W-1:0] streamWords [32];
    logic [W-1:0] expQ [$];

    mm_operand_feeder #(
        .pDATA_WIDTH (W),
        .pDIM        (4)
    ) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .feed_start (feed_start),
        .feed_busy  (feed_busy),
        .feed_done  (feed_done),
        .feed_err   (feed_err),
        .ss_tvalid  (ss_tvalid),
        .ss_tdata   (ss_tdata),
        .ss_tlast   (ss_tlast),
        .ss_tready  (ss_tready),
        .sm_tready  (sm_tready),
        .sm_tvalid  (sm_tvalid),
        .sm_tdata   (sm_tdata)
    );

    // Free-running clock and cycle counter used for latency measurement
    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Stream word i: 0..15 are A row-major, 16..31 are B row-major
    task automatic fillWords(input int dataMode);
        for (int i = 0; i < 32; i++) begin
            case (dataMode)
                0:       streamWords[i] = W'(i + 1);
                2:       streamWords[i] = 32'h8000_0000 + W'(i);
                default: streamWords[i] = $urandom;
            endcase
        end
    endtask

    // Engine operand order: A row 0, B columns 0..3 top to bottom, A rows 1..3
    task automatic buildExpected();
        expQ.delete();
        for (int c = 0; c < 4; c++) expQ.push_back(streamWords[c]);
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
                expQ.push_back(streamWords[16 + row * 4 + col]);
        for (int r = 1; r < 4; r++)
            for (int c = 0; c < 4; c++)
                expQ.push_back(streamWords[r * 4 + c]);
    endtask

    task automatic applyStimulus(input int gapPct, input int lastMode);
        int  i = 0;
        int  budget = 0;
        logic v;
        logic tl;
        while (i < 32 && budget < 3000) begin
            @(negedge axis_clk);
            budget++;
            v  = ($urandom_range(99) >= gapPct);
            tl = (i == 31);
            if (lastMode == 1 && i == 15) tl = 1'b1;
            if (lastMode == 2 && i == 31) tl = 1'b0;
            ss_tvalid = v;
            ss_tdata  = v ? streamWords[i] : W'($urandom);
            ss_tlast  = v ? tl : 1'($urandom_range(1));
            if (v && ss_tready) begin
                if (i == 31) lastHsCyc = cyc;
                i++;
            end
        end
        if (i < 32) checkOutput("loadTimeout", W'(i), 32'd32);
        @(negedge axis_clk);
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        checkOutput("readyDropAfterLast", W'(ss_tready), 32'd0);
    endtask

    task automatic collectWords(input int readyPct, input int stopAfter);
        int   n = 0;
        int   budget = 0;
        bit   stalled = 0;
        bit   seenValid = 0;
        logic r;
        logic [W-1:0] held = '0;
        logic [W-1:0] exp;
        while (n < stopAfter && budget < 5000) begin
            @(negedge axis_clk);
            budget++;
            if (stalled) begin
                checkOutput("stallValid", W'(sm_tvalid), 32'd1);
                checkOutput("stallData", sm_tdata, held);
            end
            if (sm_tvalid && !seenValid) begin
                seenValid = 1;
                checkOutput("firstLatency", W'(cyc - lastHsCyc), 32'd2);
            end
            if (readyPct < 0) r = 1'(budget % 2);
            else              r = ($urandom_range(99) < readyPct);
            sm_tready = r;
            if (sm_tvalid && r) begin
                exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
                checkOutput($sformatf("word%0d", n), sm_tdata, exp);
                n++;
                stalled = 0;
            end else begin
                stalled = sm_tvalid;
                held    = sm_tdata;
            end
        end
        if (n < stopAfter) checkOutput("emitTimeout", W'(n), W'(stopAfter));
    endtask

    task automatic pokeStarts();
        int b = 0;
        repeat (4) @(negedge axis_clk);
        feed_start = 1'b1;
        @(negedge axis_clk);
        feed_start = 1'b0;
        while (!sm_tvalid && b < 3000) begin
            @(negedge axis_clk);
            b++;
        end
        feed_start = 1'b1;
        @(negedge axis_clk);
        feed_start = 1'b0;
    endtask

    task automatic runJob(input int dataMode, input int gapPct, input int readyPct,
                          input int lastMode, input bit poke, input int resetAfter);
        fillWords(dataMode);
        buildExpected();
        repeat (2) @(negedge axis_clk);
        checkOutput("idleReadyLow", W'(ss_tready), 32'd0);
        feed_start = 1'b1;
        @(negedge axis_clk);
        feed_start = 1'b0;
        checkOutput("busyAfterStart", W'(feed_busy), 32'd1);
        checkOutput("errClearedByStart", W'(feed_err), 32'd0);
        checkOutput("readyInLoad", W'(ss_tready), 32'd1);
        fork
            applyStimulus(gapPct, lastMode);
            collectWords(readyPct, (resetAfter > 0) ? resetAfter : 32);
            if (poke) pokeStarts();
        join
        if (resetAfter > 0) begin
            #1 axis_rst_n = 1'b0;
            #1;
            checkOutput("rstValid", W'(sm_tvalid), 32'd0);
            checkOutput("rstData", sm_tdata, 32'd0);
            checkOutput("rstReady", W'(ss_tready), 32'd0);
            checkOutput("rstBusy", W'(feed_busy), 32'd0);
            checkOutput("rstDone", W'(feed_done), 32'd0);
            checkOutput("rstErr", W'(feed_err), 32'd0);
            sm_tready = 1'b0;
            expQ.delete();
            @(negedge axis_clk);
            axis_rst_n = 1'b1;
        end else begin
            @(negedge axis_clk);
            sm_tready = 1'b0;
            checkOutput("donePulse", W'(feed_done), 32'd1);
            checkOutput("validDropAtDone", W'(sm_tvalid), 32'd0);
            checkOutput("busyInDoneWait", W'(feed_busy), 32'd1);
            checkOutput("expQueueEmpty", W'(expQ.size()), 32'd0);
            @(negedge axis_clk);
            checkOutput("doneOneCycle", W'(feed_done), 32'd0);
            checkOutput("busyIdle", W'(feed_busy), 32'd0);
            checkOutput("errFlag", W'(feed_err), (lastMode != 0) ? 32'd1 : 32'd0);
        end
    endtask

    // Scenario sequence
    initial begin
        axis_rst_n = 1'b0;
        feed_start = 1'b0;
        ss_tvalid  = 1'b0;
        ss_tdata   = '0;
        ss_tlast   = 1'b0;
        sm_tready  = 1'b0;
        repeat (2) @(negedge axis_clk);
        checkOutput("resetValid", W'(sm_tvalid), 32'd0);
        checkOutput("resetData", sm_tdata, 32'd0);
        checkOutput("resetReady", W'(ss_tready), 32'd0);
        checkOutput("resetBusy", W'(feed_busy), 32'd0);
        checkOutput("resetDone", W'(feed_done), 32'd0);
        checkOutput("resetErr", W'(feed_err), 32'd0);
        axis_rst_n = 1'b1;

        $display("[TB] job: sequential data, ready always high");
        runJob(0, 0, 100, 0, 0, 0);
        $display("[TB] job: sequential data, ready toggling");
        runJob(0, 0, -1, 0, 0, 0);
        $display("[TB] job: valid gaps with ignored start pulses");
        runJob(0, 30, 100, 0, 1, 0);
        $display("[TB] job: tlast on word 15");
        runJob(1, 20, 70, 1, 0, 0);
        $display("[TB] job: tlast missing on word 31");
        runJob(1, 10, 60, 2, 0, 0);
        $display("[TB] job: reset after 20 output words");
        runJob(1, 0, 80, 0, 0, 20);
        $display("[TB] job: fresh job after reset");
        runJob(0, 0, 100, 0, 0, 0);
        $display("[TB] jobs: back to back with high-bit data");
        runJob(2, 0, 100, 0, 0, 0);
        runJob(2, 0, 100, 0, 0, 0);
        $display("[TB] jobs: random data, gaps and backpressure");
        for (int j = 0; j < 3; j++) begin
            runJob(1, $urandom_range(50), $urandom_range(100, 30), 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a bounded wait is somehow bypassed
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
